fp_mul_seq: RTL

//  Iterative IEEE-754 binary64 multiplier; the inverse-operation partner of the FPU divider, used by

---
 rtl/fp_mul_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// Iterative binary64 multiplier: shift-add mantissa product retiring BPC multiplier bits per cycle,
// round-to-nearest-even, subnormal operands and results flushed to signed zero.
module fp_mul_seq #(
    parameter int unsigned BPC = 1,
    parameter int unsigned FTZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] N1,
    input  logic [63:0] N2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out,
    output logic [4:0]  flags
);
    localparam int unsigned Iter    = (53 + BPC - 1) / BPC;
    localparam int unsigned NBits   = Iter * BPC;
    localparam int unsigned AccW    = 53 + NBits;
    localparam logic [5:0]  CntInit = 6'(Iter - 1);

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e             r_state;
    logic [5:0]         r_cnt;
    logic               r_norm_ph;
    logic               r_sign;
    logic signed [12:0] r_exp;
    logic [52:0]        r_a;
    logic [NBits-1:0]   r_b;
    logic [AccW-1:0]    r_acc;
    logic               r_spec;
    logic [63:0]        r_spec_out;
    logic [4:0]         r_spec_flags;
    logic [51:0]        r_frac;
    logic               r_g;
    logic               r_s;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [63:0]        r_out;
    logic [4:0]         r_flags;

    logic               w_nan1, w_nan2, w_inf1, w_inf2, w_zero1, w_zero2, w_sign;
    logic               w_spec;
    logic [63:0]        w_spec_out;
    logic [4:0]         w_spec_flags;
    logic signed [12:0] w_exp_sum;
    logic [NBits-1:0]   w_b_init;
    logic [52+BPC:0]    w_pp;
    logic [52+BPC:0]    w_add;
    logic [AccW-1:0]    w_acc_nxt;
    logic [105:0]       w_p;
    logic [51:0]        w_frac_n;
    logic               w_g_n, w_s_n;
    logic signed [12:0] w_exp_n;
    logic               w_inc;
    logic [52:0]        w_rnd;
    logic signed [12:0] w_exp_r;
    logic [63:0]        w_res;
    logic [4:0]         w_res_flags;

    // Operand classification; subnormal operands read as signed zero.
    always_comb begin
        w_nan1  = (N1[62:52] == 11'h7FF) && (N1[51:0] != 52'h0);
        w_nan2  = (N2[62:52] == 11'h7FF) && (N2[51:0] != 52'h0);
        w_inf1  = (N1[62:52] == 11'h7FF) && (N1[51:0] == 52'h0);
        w_inf2  = (N2[62:52] == 11'h7FF) && (N2[51:0] == 52'h0);
        w_zero1 = (N1[62:52] == 11'h0) && ((FTZ != 0) || (N1[51:0] == 52'h0));
        w_zero2 = (N2[62:52] == 11'h0) && ((FTZ != 0) || (N2[51:0] == 52'h0));
        w_sign  = N1[63] ^ N2[63];
        w_exp_sum = $signed({2'b00, N1[62:52]}) + $signed({2'b00, N2[62:52]}) - 13'sd1023;
        w_b_init = '0;
        w_b_init[52:0] = {1'b1, N2[51:0]};

        w_spec       = 1'b1;
        w_spec_out   = '0;
        w_spec_flags = '0;
        if (w_nan1 || w_nan2 || (w_inf1 && w_zero2) || (w_inf2 && w_zero1)) begin
            w_spec_out   = 64'h7FF8000000000000;
            w_spec_flags = 5'b10000;
        end else if (w_inf1 || w_inf2) begin
            w_spec_out = {w_sign, 11'h7FF, 52'h0};
        end else if (w_zero1 || w_zero2) begin
            w_spec_out   = {w_sign, 63'h0};
            w_spec_flags = 5'b00001;
        end else begin
            w_spec = 1'b0;
        end
    end

    // Accumulator holds A*B[k*BPC-1:0] aligned so that it is exactly A*B after Iter steps.
    always_comb begin
        w_pp = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (r_b[i]) w_pp = w_pp + ({{BPC{1'b0}}, r_a} << i);
        end
        w_add     = {{BPC{1'b0}}, r_acc[AccW-1:NBits]} + w_pp;
        w_acc_nxt = {w_add, r_acc[NBits-1:BPC]};
    end

    always_comb begin
        w_p = r_acc[105:0];
        if (w_p[105]) begin
            w_frac_n = w_p[104:53];
            w_g_n    = w_p[52];
            w_s_n    = |w_p[51:0];
            w_exp_n  = r_exp + 13'sd1;
        end else begin
            w_frac_n = w_p[103:52];
            w_g_n    = w_p[51];
            w_s_n    = |w_p[50:0];
            w_exp_n  = r_exp;
        end

        w_inc   = r_g & (r_s | r_frac[0]);
        w_rnd   = {1'b0, r_frac} + {52'h0, w_inc};
        // A rounding carry leaves the fraction at zero, i.e. mantissa 1.0 one binade up.
        w_exp_r = r_exp + $signed({12'h0, w_rnd[52]});
        if (w_exp_r >= 13'sd2047) begin
            w_res       = {r_sign, 11'h7FF, 52'h0};
            w_res_flags = 5'b01010;
        end else if (w_exp_r <= 13'sd0) begin
            w_res       = {r_sign, 63'h0};
            w_res_flags = 5'b00111;
        end else begin
            w_res       = {r_sign, w_exp_r[10:0], w_rnd[51:0]};
            w_res_flags = {3'b000, r_g | r_s, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_norm_ph    <= 1'b0;
            r_sign       <= 1'b0;
            r_exp        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_spec       <= 1'b0;
            r_spec_out   <= '0;
            r_spec_flags <= '0;
            r_frac       <= '0;
            r_g          <= 1'b0;
            r_s          <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_flags      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a          <= {1'b1, N1[51:0]};
                        r_b          <= w_b_init;
                        r_acc        <= '0;
                        r_sign       <= w_sign;
                        r_exp        <= w_exp_sum;
                        r_spec       <= w_spec;
                        r_spec_out   <= w_spec_out;
                        r_spec_flags <= w_spec_flags;
                        r_cnt        <= CntInit;
                        r_in_ready   <= 1'b0;
                        r_state      <= StMul;
                    end
                end
                StMul: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= r_b >> BPC;
                    if (r_cnt == 6'd0) begin
                        r_norm_ph <= 1'b0;
                        r_state   <= StNorm;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                StNorm: begin
                    // Normalise/guard/sticky first, then round and pack on the second cycle.
                    if (!r_norm_ph) begin
                        r_frac    <= w_frac_n;
                        r_g       <= w_g_n;
                        r_s       <= w_s_n;
                        r_exp     <= w_exp_n;
                        r_norm_ph <= 1'b1;
                    end else begin
                        r_out       <= r_spec ? r_spec_out : w_res;
                        r_flags     <= r_spec ? r_spec_flags : w_res_flags;
                        r_out_valid <= 1'b1;
                        r_norm_ph   <= 1'b0;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign flags     = r_flags;

endmodule
